// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: FSM state encoding,
// redirect cause encoding and the default sequential increment.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_TRAP   = 2'd2
  } rd_cause_e;

  localparam int unsigned PC_INC_DEFAULT = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry redirect buffer. Holds a redirect captured while fetch is
// held. A trap always overwrites the entry, a branch only replaces an empty
// entry or an older branch, never a pending trap.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic              clr_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  output logic              cand_vld_o,
  output logic [ADDR_W-1:0] cand_pc_o,
  output logic              pend_vld_o,
  output logic [ADDR_W-1:0] pend_pc_o
);

  rd_cause_e         cause_q, cause_d, cand_cause;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  // Candidate entry that the overwrite rules allow to be written this cycle
  always_comb begin
    cand_cause = RD_NONE;
    cand_pc_o  = branch_pc_i;
    if (trap_i) begin
      cand_cause = RD_TRAP;
      cand_pc_o  = trap_pc_i;
    end else if (branch_i && (cause_q != RD_TRAP)) begin
      cand_cause = RD_BRANCH;
      cand_pc_o  = branch_pc_i;
    end
  end

  assign cand_vld_o = (cand_cause != RD_NONE);

  // Next entry: write wins (only during hold), clear on the apply edge
  always_comb begin
    cause_d = cause_q;
    tgt_d   = tgt_q;
    if (wr_i && cand_vld_o) begin
      cause_d = cand_cause;
      tgt_d   = cand_pc_o;
    end else if (clr_i) begin
      cause_d = RD_NONE;
    end
  end

  // Cause register; reset empties the buffer
  always_ff @(posedge clk) begin
    if (rst) cause_q <= RD_NONE;
    else     cause_q <= cause_d;
  end

  // Target register; only meaningful while the cause is not NONE
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  assign pend_vld_o = (cause_q != RD_NONE);
  assign pend_pc_o  = tgt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HOLD state machine, pc register and next-PC
// mux (trap > pending redirect > branch > pc+INC).
// Optional feature macro PC_MISALIGN_CHK_EN: when defined, a selected target
// with non-zero low two bits is dropped and misalign pulses; when undefined,
// target bits [1:0] are forced to zero and misalign is tied low.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       STALL_W   = 6,
  parameter int unsigned       INC       = PC_INC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               imem_ready,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  branch_pc,
  input  logic               trap,
  input  logic [ADDR_W-1:0]  trap_pc,
  output logic               ce,
  output logic [ADDR_W-1:0]  pc,
  output logic               redirect_pending,
  output logic               misalign
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              hold, active, apply, capture;
  logic [ADDR_W-1:0] br_tgt, tr_tgt;
  logic              cand_vld, pend_vld, cap_wr;
  logic [ADDR_W-1:0] cand_pc, pend_pc;
  logic              sel_vld, sel_bad;
  logic [ADDR_W-1:0] sel_pc;
  logic              unused_bits;

  assign hold    = stall[0] | ~imem_ready;
  assign active  = (state_q != ST_BOOT);
  assign apply   = active & ~hold;
  assign capture = active & hold;

  // Upper stall bits belong to other stages; low target bits may be masked
  assign unused_bits = ^{stall, branch_pc[1:0], trap_pc[1:0]};

`ifdef PC_MISALIGN_CHK_EN
  logic misalign_q, misalign_d, cand_bad;

  assign br_tgt     = branch_pc;
  assign tr_tgt     = trap_pc;
  assign sel_bad    = sel_vld & (sel_pc[1:0] != 2'b00);
  assign cand_bad   = cand_vld & (cand_pc[1:0] != 2'b00);
  assign cap_wr     = capture & cand_vld & ~cand_bad;
  assign misalign_d = (apply & sel_bad) | (capture & cand_bad);

  // One-cycle misalign pulse for a dropped target
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign br_tgt   = {branch_pc[ADDR_W-1:2], 2'b00};
  assign tr_tgt   = {trap_pc[ADDR_W-1:2], 2'b00};
  assign sel_bad  = 1'b0;
  assign cap_wr   = capture & cand_vld;
  assign misalign = 1'b0;
`endif

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_rbuf (
    .clk         (clk),
    .rst         (rst),
    .wr_i        (cap_wr),
    .clr_i       (apply),
    .branch_i    (branch),
    .branch_pc_i (br_tgt),
    .trap_i      (trap),
    .trap_pc_i   (tr_tgt),
    .cand_vld_o  (cand_vld),
    .cand_pc_o   (cand_pc),
    .pend_vld_o  (pend_vld),
    .pend_pc_o   (pend_pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  // Next state and fetch enable
  always_comb begin
    state_d = state_q;
    ce      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        ce = 1'b1;
        if (hold) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        ce = 1'b1;
        if (!hold) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Redirect selection: new trap, then pending entry, then new branch
  always_comb begin
    sel_vld = 1'b0;
    sel_pc  = pc_q;
    if (trap) begin
      sel_vld = 1'b1;
      sel_pc  = tr_tgt;
    end else if (pend_vld) begin
      sel_vld = 1'b1;
      sel_pc  = pend_pc;
    end else if (branch) begin
      sel_vld = 1'b1;
      sel_pc  = br_tgt;
    end
  end

  // Next pc: hold in BOOT/held cycles, redirect or sequential otherwise
  always_comb begin
    pc_d = pc_q;
    if (apply) begin
      if (sel_vld) begin
        if (!sel_bad) pc_d = sel_pc;
      end else begin
        pc_d = pc_q + ADDR_W'(INC);
      end
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VEC;
    else     pc_q <= pc_d;
  end

  assign pc               = pc_q;
  assign redirect_pending = pend_vld;

endmodule
